// File: rtl/present_core_iter.sv
// -----------------------------------------------------------------------------
// present_core_iter
//
// Iterative PRESENT block-cipher core with run-time encrypt/decrypt, 80- or
// 128-bit keys and a configurable number of cipher steps per clock. One block
// is processed at a time and is framed by valid/ready handshakes on both
// sides.
//
// A block is 32 steps. In encrypt mode, steps 1..31 are full rounds (key add,
// S-box layer, bit permutation, key-schedule update) and step 32 is the final
// key add. Decrypt mode runs the same schedule backwards, starting from the
// final key-register state, and ends with the user key in the key register.
//
// Parameters
//   KEY_W    key width, 80 or 128
//   UNROLL   steps computed per clock, 1/2/4/8
//   N_STEPS  steps per block, fixed at 32
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   core can accept a request (IDLE, or DONE while out_ready=1)
//   in_dec     0 = encrypt, 1 = decrypt
//   in_data    plaintext (enc) or ciphertext (dec)
//   in_key     user key (enc) or final key-register state K32 (dec)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   ciphertext or plaintext
//   out_key    key-register state at completion (K32 after enc, user key
//              after dec)
// -----------------------------------------------------------------------------
module present_core_iter #(
    parameter int KEY_W   = 128,
    parameter int UNROLL  = 2,
    parameter int N_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dec,
    input  logic [63:0]      in_data,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [KEY_W-1:0] out_key
);

    // Counter holds 1..33: the step index of lane 0, one past 32 once done.
    localparam int CNT_W  = 6;
    // Low bit of the 5-bit field that takes the round counter.
    localparam int XOR_LO = (KEY_W == 80) ? 15 : 62;

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("present_core_iter: KEY_W must be 80 or 128");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("present_core_iter: UNROLL must be 1, 2, 4 or 8");
    end
    if (N_STEPS != 32) begin : g_bad_steps
        $error("present_core_iter: N_STEPS is fixed at 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Cipher state and key register travelling together through one step.
    typedef struct packed {
        logic [63:0]      s;
        logic [KEY_W-1:0] k;
    } blk_t;

    // -------------------------------------------------------------------------
    // Cipher primitives
    // -------------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put (bit 0 maps to itself).
    function automatic logic [63:0] perm(input logic [63:0] s);
        logic [63:0] r;
        r[63] = s[63];
        for (int i = 0; i < 63; i++) begin
            r[(16 * i) % 63] = s[i];
        end
        return r;
    endfunction

    function automatic logic [63:0] inv_perm(input logic [63:0] s);
        logic [63:0] r;
        r[63] = s[63];
        for (int i = 0; i < 63; i++) begin
            r[i] = s[(16 * i) % 63];
        end
        return r;
    endfunction

    // Forward key schedule: rotate left 61, S-box the top nibble(s), then
    // fold in the 5-bit round counter.
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
        r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
        end
        r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ rc;
        return r;
    endfunction

    // Exact inverse of key_fwd, undoing its operations in reverse order.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = k;
        r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ rc;
        r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128) begin
            r[KEY_W-5 -: 4] = inv_sbox(r[KEY_W-5 -: 4]);
        end
        return {r[60:0], r[KEY_W-1:61]};
    endfunction

    // One cipher step with index 'step' (1..32). Indices outside that range
    // pass the block through untouched, so an unrolled lane can never run
    // past the last step.
    function automatic blk_t step_fn(input blk_t             cur,
                                     input logic             dec,
                                     input logic [CNT_W-1:0] step);
        blk_t       r;
        logic [4:0] j;
        r = cur;
        // Decrypt walks the rounds backwards: step 2 undoes round 31, ...,
        // step 32 undoes round 1.
        j = 5'(CNT_W'(N_STEPS + 1) - step);
        if (step != '0 && step <= CNT_W'(N_STEPS)) begin
            if (!dec) begin
                if (step == CNT_W'(N_STEPS)) begin
                    r.s = cur.s ^ cur.k[KEY_W-1 -: 64];
                end else begin
                    r.s = perm(sbox_layer(cur.s ^ cur.k[KEY_W-1 -: 64]));
                    r.k = key_fwd(cur.k, step[4:0]);
                end
            end else begin
                if (step == CNT_W'(1)) begin
                    r.s = cur.s ^ cur.k[KEY_W-1 -: 64];
                end else begin
                    r.k = key_inv(cur.k, j);
                    r.s = inv_sbox_layer(inv_perm(cur.s)) ^ r.k[KEY_W-1 -: 64];
                end
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    fsm_t             fsm_q, fsm_d;
    logic [63:0]      data_q;
    logic [KEY_W-1:0] key_q;
    logic             dec_q;
    logic [CNT_W-1:0] cnt_q;

    blk_t             chain;
    logic             last_cycle;
    logic             accept;

    // UNROLL steps chained combinationally; lane l executes step cnt_q + l.
    always_comb begin
        chain.s = data_q;
        chain.k = key_q;
        for (int l = 0; l < UNROLL; l++) begin
            // NOTE: blocking assignments here are deliberate: each lane must
            // see the previous lane's result within the same evaluation.
            chain = step_fn(chain, dec_q, cnt_q + CNT_W'(l));
        end
    end

    // This cycle's lanes reach step 32.
    assign last_cycle = (cnt_q + CNT_W'(UNROLL - 1)) >= CNT_W'(N_STEPS);
    assign accept     = in_valid & in_ready;

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can leave a latch behind.
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Back-to-back: a retiring result frees the core this edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    fsm_d = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            fsm_q  <= IDLE;
            data_q <= '0;
            key_q  <= '0;
            dec_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                data_q <= in_data;
                key_q  <= in_key;
                dec_q  <= in_dec;
                cnt_q  <= CNT_W'(1);
            end else if (fsm_q == RUN) begin
                data_q <= chain.s;
                key_q  <= chain.k;
                cnt_q  <= cnt_q + CNT_W'(UNROLL);
            end
        end
    end

    // Result registers double as the working state; they only change on
    // accept or in RUN, so they hold steady throughout DONE.
    assign out_data = data_q;
    assign out_key  = key_q;

endmodule

// File: tb/tb_present_core_iter.sv
// -----------------------------------------------------------------------------
// tb_present_core_iter
//
// Self-checking bench for present_core_iter. Eight instances cover every
// KEY_W (80/128) x UNROLL (1/2/4/8) combination; instance g has
// KEY_W = 80 for g<4 else 128, and UNROLL = 1 << (g % 4). Expected results
// come from a loop-based PRESENT encryption model in this file; decryption is
// checked by round-tripping the encryption result back to the original
// plaintext and user key.
// -----------------------------------------------------------------------------
module tb_present_core_iter;

    localparam int NI = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NI-1:0]        in_valid;
    logic [NI-1:0]        out_ready;
    logic [NI-1:0]        in_ready;
    logic [NI-1:0]        out_valid;
    logic                 in_dec;
    logic [63:0]          in_data;
    logic [127:0]         in_key;
    logic [NI-1:0][63:0]  out_data;
    logic [NI-1:0][127:0] out_key;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int KW = (g < 4) ? 80 : 128;
        localparam int UR = 1 << (g % 4);
        logic          ir;
        logic          ov;
        logic [63:0]   od;
        logic [KW-1:0] okey;

        present_core_iter #(
            .KEY_W  (KW),
            .UNROLL (UR),
            .N_STEPS(32)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (ir),
            .in_dec   (in_dec),
            .in_data  (in_data),
            .in_key   (in_key[KW-1:0]),
            .out_valid(ov),
            .out_ready(out_ready[g]),
            .out_data (od),
            .out_key  (okey)
        );

        assign in_ready[g]  = ir;
        assign out_valid[g] = ov;
        assign out_data[g]  = od;
        assign out_key[g]   = 128'(okey);
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[63 - 4 * int'(x) -: 4];
    endfunction

    function automatic logic [63:0] model_enc(input  logic [63:0]  pt,
                                              input  logic [127:0] key,
                                              input  int           kw,
                                              output logic [127:0] k32);
        logic [63:0]  s, t;
        logic [127:0] k, nk;
        int           lo;
        s  = pt;
        k  = key;
        lo = (kw == 80) ? 15 : 62;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[kw-1 -: 64];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = m_sbox(s[4*n +: 4]);
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s  = t;
            nk = '0;
            for (int b = 0; b < kw; b++) nk[(b + 61) % kw] = k[b];
            k = nk;
            k[kw-1 -: 4] = m_sbox(k[kw-1 -: 4]);
            if (kw == 128) k[kw-5 -: 4] = m_sbox(k[kw-5 -: 4]);
            k[lo +: 5] = k[lo +: 5] ^ 5'(r);
        end
        s   = s ^ k[kw-1 -: 64];
        k32 = k;
        return s;
    endfunction

    // ---------------------------------------------------------------------
    // Checking and driving
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one request to instance idx, wait for the result, then retire it.
    // lat counts clock edges from the accepting edge to out_valid.
    task automatic run_block(input  int           idx,
                             input  logic         dec,
                             input  logic [63:0]  d,
                             input  logic [127:0] k,
                             output logic [63:0]  rd,
                             output logic [127:0] rk,
                             output int           lat);
        int t;
        @(negedge clk);
        in_valid[idx] = 1'b1;
        in_dec        = dec;
        in_data       = d;
        in_key        = k;
        t = 0;
        while (!in_ready[idx] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("accept_ready[%0d]", idx), 128'(in_ready[idx]), 128'(1));
        @(posedge clk);
        #1;
        // Scramble the inputs: the core must have sampled them on the edge.
        in_valid[idx] = 1'b0;
        in_dec        = ~dec;
        in_data       = {$urandom, $urandom};
        in_key        = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        @(negedge clk);
        while (!out_valid[idx] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = out_data[idx];
        rk = out_key[idx];
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  rd, rd2, pt, pt2, exp_d, exp_d2;
        logic [127:0] rk, rk2, key, key2, exp_k, exp_k2;
        int           lat, kw, exp_lat, t;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_dec    = 1'b0;
        in_data   = '0;
        in_key    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state on every instance.
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_in_ready[%0d]", i),  128'(in_ready[i]),  128'(1));
            check($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
            check($sformatf("rst_out_data[%0d]", i),  128'(out_data[i]),  128'(0));
            check($sformatf("rst_out_key[%0d]", i),   out_key[i],         128'(0));
        end

        // Known-answer vectors, KEY_W=80 UNROLL=2 (instance 1).
        run_block(1, 1'b0, 64'h0, 128'h0, rd, rk, lat);
        check("kat80_zero", 128'(rd), 128'(64'h5579C1387B228445));
        check("kat80_zero_lat", 128'(lat), 128'(16));
        exp_d = model_enc(64'h0, 128'h0, 80, exp_k);
        check("kat80_zero_k32", rk, exp_k);

        run_block(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, {48'h0, {80{1'b1}}}, rd, rk, lat);
        check("kat80_ones", 128'(rd), 128'(64'h3333DCD3213210D2));

        run_block(1, 1'b0, 64'h0, {48'h0, {80{1'b1}}}, rd, rk, lat);
        check("kat80_pt0_key1", 128'(rd), 128'(64'hE72C46C0F5945049));

        // Known-answer vector, KEY_W=128 UNROLL=2 (instance 5).
        run_block(5, 1'b0, 64'h0, 128'h0, rd, rk, lat);
        check("kat128_zero", 128'(rd), 128'(64'h96DB702A2E6900AF));
        check("kat128_zero_lat", 128'(lat), 128'(16));

        // Random round trips across every key width / unroll combination.
        for (int i = 0; i < NI; i++) begin
            kw      = (i < 4) ? 80 : 128;
            exp_lat = 32 >> (i % 4);
            for (int rep = 0; rep < 2; rep++) begin
                pt  = {$urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                if (kw == 80) key[127:80] = '0;
                exp_d = model_enc(pt, key, kw, exp_k);
                run_block(i, 1'b0, pt, key, rd, rk, lat);
                check($sformatf("enc_data[%0d]", i), 128'(rd), 128'(exp_d));
                check($sformatf("enc_key[%0d]", i),  rk,        exp_k);
                check($sformatf("enc_lat[%0d]", i),  128'(lat), 128'(exp_lat));
                run_block(i, 1'b1, rd, rk, rd2, rk2, lat);
                check($sformatf("dec_data[%0d]", i), 128'(rd2), 128'(pt));
                check($sformatf("dec_key[%0d]", i),  rk2,       key);
                check($sformatf("dec_lat[%0d]", i),  128'(lat), 128'(exp_lat));
            end
        end

        // Output back-pressure followed by retire-and-accept on one edge.
        pt     = {$urandom, $urandom};
        key    = {48'h0, $urandom, $urandom, 16'(($urandom))};
        pt2    = {$urandom, $urandom};
        key2   = {48'h0, $urandom, $urandom, 16'(($urandom))};
        exp_d  = model_enc(pt, key, 80, exp_k);
        exp_d2 = model_enc(pt2, key2, 80, exp_k2);
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_dec      = 1'b0;
        in_data     = pt;
        in_key      = key;
        check("hs_idle_ready", 128'(in_ready[1]), 128'(1));
        @(posedge clk);
        #1;
        in_data = pt2;   // next request waits with in_valid held high
        in_key  = key2;
        t = 0;
        @(negedge clk);
        check("hs_run_ready", 128'(in_ready[1]), 128'(0));
        while (!out_valid[1] && t < 200) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        check("hs_lat1", 128'(t), 128'(16));
        for (int c = 0; c < 10; c++) begin
            check($sformatf("hs_hold_valid[%0d]", c), 128'(out_valid[1]), 128'(1));
            check($sformatf("hs_hold_data[%0d]", c),  128'(out_data[1]),  128'(exp_d));
            check($sformatf("hs_hold_key[%0d]", c),   out_key[1],         exp_k);
            check($sformatf("hs_hold_ready[%0d]", c), 128'(in_ready[1]),  128'(0));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready[1] = 1'b1;
        #1;
        check("hs_comb_ready", 128'(in_ready[1]), 128'(1));
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b0;
        in_data      = {$urandom, $urandom};
        in_key       = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("hs_b2b_valid", 128'(out_valid[1]), 128'(0));
        check("hs_b2b_ready", 128'(in_ready[1]),  128'(0));
        t = 0;
        while (!out_valid[1] && t < 200) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        check("hs_lat2",  128'(t),           128'(16));
        check("hs_data2", 128'(out_data[1]), 128'(exp_d2));
        check("hs_key2",  out_key[1],        exp_k2);
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;

        // Reset while instance 1 is at step 5.
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_dec      = 1'b0;
        in_data     = {$urandom, $urandom};
        in_key      = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);          // accept: counter = 1
        #1 in_valid[1] = 1'b0;
        repeat (2) @(posedge clk); // steps 1..4 done, counter = 5
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstrun_valid",    128'(out_valid[1]), 128'(0));
        check("rstrun_ready",    128'(in_ready[1]),  128'(1));
        check("rstrun_data",     128'(out_data[1]),  128'(0));
        check("rstrun_key",      out_key[1],         128'(0));
        repeat (20) @(negedge clk);
        check("rstrun_no_output", 128'(out_valid[1]), 128'(0));

        pt    = {$urandom, $urandom};
        key   = {48'h0, $urandom, $urandom, 16'(($urandom))};
        exp_d = model_enc(pt, key, 80, exp_k);
        run_block(1, 1'b0, pt, key, rd, rk, lat);
        check("post_rst_data", 128'(rd),  128'(exp_d));
        check("post_rst_key",  rk,        exp_k);
        check("post_rst_lat",  128'(lat), 128'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
